data_memory_ctrl: RTL and testbench

- Parametrised, byte-addressable, little-endian data memory with a request/response handshake.
- Supports byte, half-word and word loads/stores, with sign or zero extension on loads.
- Flags misaligned, out-of-range and illegal-size accesses, and models a configurable wait-state count.
- Sits in the MEM stage; the pipeline stalls on ready_o and rvalid_o.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_byte_array.sv | 26 ++
 rtl/data_memory_ctrl.sv | 128 ++++++++++++
 tb/tb_data_memory_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // The illegal encoding maps to 4 so the range check stays well defined; it errors anyway.
  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-wide storage with a 4-lane byte-enable write and a 4-byte consecutive read.
module dmem_byte_array #(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [7:0] r_mem [DEPTH_BYTES];

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < 4; k++) begin
      if (i_we[k]) r_mem[i_addr + AW'(k)] <= i_wdata[8*k +: 8];
    end
  end

  // Lane k reads address+k; lanes past the top wrap, but the controller never uses them.
  for (genvar k = 0; k < 4; k++) begin : g_rd
    assign o_rdata[8*k +: 8] = r_mem[i_addr + AW'(k)];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: serialised request/response FSM with wait states,
// alignment/range checking, byte-lane steering and load extension.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] data_o,
  output logic        err_o
);

  localparam int          AW      = $clog2(DEPTH_BYTES);
  localparam logic [32:0] DEPTH33 = 33'(DEPTH_BYTES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_data;
  logic        r_rvalid;
  logic        r_err;

  logic [2:0]  w_nbytes;
  logic [32:0] w_last;
  logic        w_err;
  logic        w_commit;
  logic [3:0]  w_be;
  logic [31:0] w_rdata;
  logic [31:0] w_ldata;

  assign w_nbytes = bytes_of(r_size);
  // Last byte touched, computed in 33 bits so accesses near 2^32 cannot wrap into range.
  assign w_last   = {1'b0, r_addr} + 33'(w_nbytes) - 33'd1;
  assign w_err    = (r_size == 2'b11)
                  | ((r_size == SZ_HALF) & r_addr[0])
                  | ((r_size == SZ_WORD) & (|r_addr[1:0]))
                  | (w_last >= DEPTH33);
  assign w_commit = (r_state == BUSY) && (r_cnt == 4'd0);

  for (genvar k = 0; k < 4; k++) begin : g_be
    assign w_be[k] = w_commit & r_we & ~w_err & (3'(k) < w_nbytes);
  end

  always_comb begin
    w_ldata = w_rdata;
    case (r_size)
      SZ_BYTE: w_ldata = {{24{~r_uns & w_rdata[7]}},  w_rdata[7:0]};
      SZ_HALF: w_ldata = {{16{~r_uns & w_rdata[15]}}, w_rdata[15:0]};
      default: w_ldata = w_rdata;
    endcase
  end

  dmem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (AW)
  ) u_mem (
    .i_clk   (clk_i),
    .i_we    (w_be),
    .i_addr  (r_addr[AW-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_size   <= SZ_BYTE;
      r_uns    <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_data   <= 32'd0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rvalid <= 1'b0;
          if (req_i) begin
            r_we    <= we_i;
            r_size  <= size_i;
            r_uns   <= unsigned_i;
            r_addr  <= addr_i;
            r_wdata <= data_i;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_err    <= w_err;
            if (!r_we && !w_err) r_data <= w_ldata;
            r_rvalid <= 1'b1;
            r_state  <= RESP;
          end
        end
        RESP: begin
          r_rvalid <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o  = (r_state == IDLE);
  assign rvalid_o = r_rvalid;
  assign data_o   = r_data;
  assign err_o    = r_err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed and randomized bench driving two controllers (0 and 3 wait states)
// in lockstep against a byte-array reference model.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        rdy0, rv0, e0, rdy3, rv3, e3;
  logic [31:0] d0, d3;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem_m [1024];
  logic [31:0] exp_d;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH_BYTES(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .data_i(wdata),
    .ready_o(rdy0), .rvalid_o(rv0), .data_o(d0), .err_o(e0));

  data_memory_ctrl #(.DEPTH_BYTES(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .data_i(wdata),
    .ready_o(rdy3), .rvalid_o(rv3), .data_o(d3), .err_o(e3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [1:0] s, input logic [31:0] a);
    int     n = nb(s);
    longint last = longint'({32'd0, a}) + longint'(n) - 1;
    return (s == 2'd3) || ((a % 32'(n)) != 32'd0) || (last >= 1024);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input bit u, input logic [31:0] a);
    int          n = nb(s);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < n; i++) r = r | (32'(mem_m[10'(a + 32'(i))]) << (8 * i));
    if (!u && n < 4 && r[8*n-1]) r = r | ~((32'd1 << (8 * n)) - 32'd1);
    return r;
  endfunction

  task automatic model_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] dat);
    for (int i = 0; i < nb(s); i++) mem_m[10'(a + 32'(i))] = dat[8*i +: 8];
  endtask

  task automatic access(input bit w, input logic [1:0] s, input bit u,
                        input logic [31:0] a, input logic [31:0] dat, input string tag);
    int lat0 = -1, lat3 = -1, np0 = 0, np3 = 0, busy3 = 0;
    bit idle3 = 1'b0;
    bit ee;
    @(negedge clk);
    chk({tag, ".rdy0"}, 32'(rdy0), 32'd1);
    chk({tag, ".rdy3"}, 32'(rdy3), 32'd1);
    we = w; size = s; uns = u; addr = a; wdata = dat; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    ee = model_err(s, a);
    if (!ee) begin
      if (w) model_store(s, a, dat);
      else   exp_d = model_load(s, u, a);
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rv0) begin
        np0++;
        if (lat0 < 0) begin
          lat0 = c;
          chk({tag, ".err0"}, 32'(e0), 32'(ee));
          chk({tag, ".data0"}, d0, exp_d);
        end
      end
      if (rv3) begin
        np3++;
        if (lat3 < 0) begin
          lat3 = c;
          chk({tag, ".err3"}, 32'(e3), 32'(ee));
          chk({tag, ".data3"}, d3, exp_d);
        end
      end
      if (!idle3) begin
        if (rdy3) idle3 = 1'b1;
        else      busy3++;
      end
    end
    chk({tag, ".lat0"}, lat0, 32'd2);
    chk({tag, ".lat3"}, lat3, 32'd5);
    chk({tag, ".pulses0"}, np0, 32'd1);
    chk({tag, ".pulses3"}, np3, 32'd1);
    chk({tag, ".busy3"}, busy3, 32'd5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int f0, s0, f3, s3, pulses;
    logic [1:0]  rs;
    logic [31:0] ra;
    int          r;
    for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
    exp_d = 32'd0;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    #12;
    chk("rst.rdy0", 32'(rdy0), 32'd1);
    chk("rst.rv0", 32'(rv0), 32'd0);
    chk("rst.d0", d0, 32'd0);
    chk("rst.e0", 32'(e0), 32'd0);
    chk("rst.rdy3", 32'(rdy3), 32'd1);
    chk("rst.d3", d3, 32'd0);
    @(negedge clk) rst = 1'b0;

    access(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, "st_w10");
    access(0, 2'd2, 0, 32'h10, 32'h0, "ld_w10");
    chk("rt_word", d0, 32'hDEADBEEF);
    access(0, 2'd0, 1, 32'h10, 32'h0, "ld_bu10");
    chk("rt_byte", d3, 32'h000000EF);

    access(1, 2'd2, 0, 32'h20, 32'h5A5A5A5A, "st_w20");
    access(1, 2'd0, 0, 32'h21, 32'h12345680, "st_b21");
    access(0, 2'd0, 0, 32'h21, 32'h0, "ld_bs21");
    chk("sext_byte", d0, 32'hFFFFFF80);
    access(0, 2'd0, 1, 32'h21, 32'h0, "ld_bu21");
    chk("zext_byte", d0, 32'h00000080);
    access(1, 2'd1, 0, 32'h22, 32'hABCD8001, "st_h22");
    access(0, 2'd1, 0, 32'h22, 32'h0, "ld_hs22");
    chk("sext_half", d3, 32'hFFFF8001);
    access(0, 2'd0, 1, 32'h20, 32'h0, "ld_bu20");
    chk("neighbour", d0, 32'h0000005A);

    access(0, 2'd2, 0, 32'h10, 32'h0, "ld_w10b");
    access(1, 2'd2, 0, 32'h13, 32'hCAFEF00D, "st_mis13");
    access(0, 2'd1, 0, 32'h05, 32'h0, "ld_mis05");
    access(0, 2'd3, 0, 32'h10, 32'h0, "ld_ill");
    chk("err_hold", d0, 32'hDEADBEEF);
    access(0, 2'd2, 0, 32'h10, 32'h0, "ld_w10c");
    chk("after_err", d3, 32'hDEADBEEF);

    access(1, 2'd2, 0, 32'h3FC, 32'h01020304, "st_w3fc");
    access(1, 2'd2, 0, 32'h3FE, 32'hFFFFFFFF, "st_w3fe");
    access(1, 2'd2, 0, 32'h400, 32'hFFFFFFFF, "st_w400");
    access(1, 2'd0, 0, 32'hFFFFFFFF, 32'h77, "st_bmax");
    access(0, 2'd2, 0, 32'h3FC, 32'h0, "ld_w3fc");
    chk("range_top", d0, 32'h01020304);

    // req held high: each DUT re-accepts only after returning to IDLE
    f0 = -1; s0 = -1; f3 = -1; s3 = -1;
    @(negedge clk);
    we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h10; req = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (rv0) begin if (f0 < 0) f0 = c; else if (s0 < 0) s0 = c; end
      if (rv3) begin if (f3 < 0) f3 = c; else if (s3 < 0) s3 = c; end
    end
    req = 1'b0;
    repeat (10) @(negedge clk);
    exp_d = model_load(2'd2, 1'b0, 32'h10);
    chk("hold.first0", f0, 32'd2);
    chk("hold.gap0", s0 - f0, 32'd3);
    chk("hold.first3", f3, 32'd5);
    chk("hold.gap3", s3 - f3, 32'd6);
    chk("hold.d3", d3, exp_d);

    access(1, 2'd2, 0, 32'h40, 32'hA5A5A5A5, "st_w40");
    @(negedge clk);
    we = 1'b1; size = 2'd2; addr = 32'h40; wdata = 32'h11223344; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort.rdy0", 32'(rdy0), 32'd1);
    chk("abort.rdy3", 32'(rdy3), 32'd1);
    chk("abort.rv0", 32'(rv0), 32'd0);
    chk("abort.d0", d0, 32'd0);
    chk("abort.d3", d3, 32'd0);
    exp_d = 32'd0;
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv0 || rv3) pulses++;
    end
    chk("abort.no_rvalid", pulses, 32'd0);
    access(0, 2'd2, 0, 32'h40, 32'h0, "ld_w40");
    chk("abort.mem", d3, 32'hA5A5A5A5);

    for (int i = 0; i < 16; i++) access(1, 2'd2, 0, 32'h100 + 32'(4 * i), $urandom, "init_lo");
    for (int i = 0; i < 4; i++) access(1, 2'd2, 0, 32'h3F0 + 32'(4 * i), $urandom, "init_hi");
    for (int i = 0; i < 40; i++) begin
      r  = int'($urandom_range(0, 9));
      rs = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r  = int'($urandom_range(0, 9));
      ra = (r < 7) ? 32'h100 + ($urandom % 64) :
           (r < 9) ? 32'h3F0 + ($urandom % 16) : 32'hFFFFFFF0 + ($urandom % 16);
      access(1'($urandom % 2), rs, 1'($urandom % 2), ra, $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
